// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into memory while the core is held in
// reset, reads the region back to confirm an additive checksum, then releases the core.
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 16,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  manual_mem,
    output logic                  core_reset_n,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_VERIFY  = 3'd2,
        S_COMPARE = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(DEPTH - BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO    = {ADDR_WIDTH{1'b0}};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   len_r;
    logic [ADDR_WIDTH-1:0]   count_r;
    logic [ADDR_WIDTH-1:0]   rd_cnt_r;
    logic [ADDR_WIDTH-1:0]   cap_cnt_r;
    logic [DATA_WIDTH-1:0]   rb_sum_r;
    logic                    addr_vld_r;
    logic                    rd_vld_r;
    logic                    len_ok_s;
    logic                    hs_s;

    function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] val);
        return acc + val;
    endfunction

    // Length check and stream handshake decode.
    always_comb begin
        len_ok_s = (len != ZERO) && (len <= MAX_LEN);
        hs_s     = in_valid & in_ready;
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= S_IDLE;
            len_r           <= ZERO;
            count_r         <= ZERO;
            rd_cnt_r        <= ZERO;
            cap_cnt_r       <= ZERO;
            rb_sum_r        <= {DATA_WIDTH{1'b0}};
            addr_vld_r      <= 1'b0;
            rd_vld_r        <= 1'b0;
            in_ready        <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= ZERO;
            mem_din         <= {DATA_WIDTH{1'b0}};
            manual_mem      <= 1'b1;
            core_reset_n    <= 1'b0;
            trigger_program <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_code        <= 2'b00;
            checksum        <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    trigger_program <= 1'b0;
                    if (start) begin
                        manual_mem   <= 1'b1;
                        core_reset_n <= 1'b0;
                        done         <= 1'b0;
                        mem_we       <= 1'b0;
                        if (len_ok_s) begin
                            len_r    <= len;
                            count_r  <= ZERO;
                            checksum <= {DATA_WIDTH{1'b0}};
                            rb_sum_r <= {DATA_WIDTH{1'b0}};
                            err_code <= 2'b00;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state_r  <= S_LOAD;
                        end else begin
                            err_code <= 2'b01;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                            state_r  <= S_ERROR;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_ready) begin
                        if (hs_s) begin
                            mem_we   <= 1'b1;
                            mem_addr <= BASE + count_r;
                            mem_din  <= in_data;
                            checksum <= csum_add(checksum, in_data);
                            count_r  <= count_r + ONE;
                            if (count_r + ONE == len_r) begin
                                in_ready <= 1'b0;
                            end
                        end else begin
                            mem_we <= 1'b0;
                        end
                    end else begin
                        // in_ready low here means the final write is on the bus this cycle.
                        mem_we     <= 1'b0;
                        mem_addr   <= BASE;
                        rd_cnt_r   <= ONE;
                        cap_cnt_r  <= ZERO;
                        addr_vld_r <= 1'b1;
                        rd_vld_r   <= 1'b0;
                        state_r    <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    rd_vld_r <= addr_vld_r;
                    if (rd_cnt_r < len_r) begin
                        mem_addr   <= BASE + rd_cnt_r;
                        rd_cnt_r   <= rd_cnt_r + ONE;
                        addr_vld_r <= 1'b1;
                    end else begin
                        addr_vld_r <= 1'b0;
                    end
                    if (rd_vld_r) begin
                        rb_sum_r  <= csum_add(rb_sum_r, mem_dout);
                        cap_cnt_r <= cap_cnt_r + ONE;
                        if (cap_cnt_r + ONE == len_r) begin
                            state_r <= S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    if (rb_sum_r == checksum) begin
                        manual_mem      <= 1'b0;
                        core_reset_n    <= 1'b1;
                        trigger_program <= 1'b1;
                        busy            <= 1'b0;
                        state_r         <= S_RELEASE;
                    end else begin
                        err_code <= 2'b10;
                        busy     <= 1'b0;
                        state_r  <= S_ERROR;
                    end
                end
                S_RELEASE: begin
                    trigger_program <= 1'b0;
                    done            <= 1'b1;
                    state_r         <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are accepted
// and compared against the memory bus; an ideal memory model answers readback.
module tb_prog_loader;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int BASE  = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          manual_mem;
    logic          core_reset_n;
    logic          trigger_program;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    logic [DW-1:0] checksum;

    prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .manual_mem(manual_mem), .core_reset_n(core_reset_n),
        .trigger_program(trigger_program), .busy(busy), .done(done),
        .err_code(err_code), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal synchronous memory; optionally corrupts address 20 on write.
    logic [7:0] mem [0:63];
    logic       corrupt;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= (corrupt && mem_addr == 16'd20) ? 8'h00 : mem_din;
        mem_dout <= mem[mem_addr[5:0]];
    end

    logic [23:0] exp_q[$];
    logic [7:0]  stim[$];
    int          wr_cnt;
    int          trig_cnt;
    int          exp_len;
    logic [63:0] rd_mask;

    // Write scoreboard, readback address capture and trigger counting.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wr_cnt++;
                if (exp_q.size() > 0) check("wr_addr_data", {40'h0, mem_addr, mem_din}, {40'h0, exp_q.pop_front()});
            end
            if (busy && !mem_we && exp_len > 0 && wr_cnt == exp_len) rd_mask[mem_addr[5:0]] = 1'b1;
            if (trigger_program) trig_cnt++;
        end
    end

    function automatic logic [63:0] outvec();
        return {23'h0, in_ready, mem_we, mem_addr, mem_din, manual_mem, core_reset_n,
                trigger_program, busy, done, err_code, checksum};
    endfunction

    localparam logic [63:0] RST_VEC = {23'h0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0,
                                       1'b0, 1'b0, 1'b0, 2'b00, 8'h00};

    task automatic clear_sb(input int n);
        exp_q.delete();
        wr_cnt   = 0;
        trig_cnt = 0;
        rd_mask  = 64'h0;
        exp_len  = n;
    endtask

    task automatic run_load(input int n, input bit bubble, input bit expect_ok, input string tag);
        logic [7:0]  sum;
        logic [63:0] mask;
        int          waitc;
        sum  = 8'h00;
        mask = 64'h0;
        clear_sb(n);
        start = 1'b1;
        len   = n[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_start"}, {60'h0, busy, core_reset_n, manual_mem, done}, 64'h0000_0000_0000_000A);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            waitc = 0;
            while (!in_ready && waitc < 20) begin
                @(posedge clk); #1;
                waitc++;
            end
            check({tag, "_rdy"}, {63'h0, in_ready}, 64'h1);
            if (!in_ready) break;
            exp_q.push_back({16'(BASE + i), stim[i]});
            sum = sum + stim[i];
            mask[BASE + i] = 1'b1;
            @(posedge clk); #1;
            if (bubble) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        waitc = 0;
        while (!done && err_code == 2'b00 && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_csum"}, {56'h0, checksum}, {56'h0, sum});
        check({tag, "_writes"}, wr_cnt, n);
        check({tag, "_pending"}, exp_q.size(), 0);
        if (expect_ok) begin
            check({tag, "_done"}, {62'h0, done, err_code != 2'b00}, 64'h2);
            check({tag, "_release"}, {62'h0, manual_mem, core_reset_n}, 64'h1);
            check({tag, "_trig"}, trig_cnt, 1);
            check({tag, "_reads"}, rd_mask, mask);
        end else begin
            check({tag, "_err"}, {62'h0, err_code}, 64'h2);
            check({tag, "_held"}, {61'h0, done, manual_mem, core_reset_n}, 64'h2);
            check({tag, "_trig"}, trig_cnt, 0);
        end
    endtask

    task automatic bad_len(input logic [15:0] n, input string tag);
        clear_sb(0);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_err"}, {62'h0, err_code}, 64'h1);
        check({tag, "_core"}, {62'h0, core_reset_n, busy}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_nowr"}, wr_cnt, 0);
    endtask

    task automatic load_stream1();
        stim = '{8'hA9, 8'h04, 8'h85, 8'h02, 8'hA9, 8'h10, 8'hA9, 8'hFF,
                 8'h85, 8'h0C, 8'hA9, 8'h03, 8'h85, 8'h04, 8'h85, 8'h06};
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        reset    = 1'b1;
        start    = 1'b0;
        len      = 16'h0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        corrupt  = 1'b0;
        clear_sb(0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", outvec(), RST_VEC);
        reset = 1'b0;
        @(posedge clk); #1;

        bad_len(16'd0, "len0");
        bad_len(16'd17, "len17");

        load_stream1();
        run_load(16, 1'b0, 1'b1, "s1");
        check("s1_csum_const", {56'h0, checksum}, 64'hE6);
        run_load(16, 1'b1, 1'b1, "s2");

        corrupt = 1'b1;
        run_load(16, 1'b0, 1'b0, "s4");
        corrupt = 1'b0;

        // Abort after five accepted bytes.
        start = 1'b1;
        len   = 16'd16;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("s5_async_rst", outvec(), RST_VEC);
        repeat (2) @(posedge clk);
        #1;
        check("s5_rst_hold", outvec(), RST_VEC);
        reset = 1'b0;
        @(posedge clk); #1;
        run_load(16, 1'b0, 1'b1, "s5");

        stim = '{8'hEA, 8'hEA};
        run_load(2, 1'b0, 1'b1, "s6");
        check("s6_csum_const", {56'h0, checksum}, 64'hD4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
